// File: rtl/vga_capture_if.sv
// Signal bundle between a Tiny VGA Pmod stream source and the vga_capture receiver.
// The source drives the 8-bit pin bus and the receiver returns pixel and lock status.
interface vga_capture_if;
    logic [7:0]  vga_in;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [5:0]  pix_rgb;
    logic        frame_start;
    logic        locked;
    logic        err_pulse;
    logic [15:0] frame_sig;

    modport master (
        output vga_in,
        input  pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, err_pulse, frame_sig
    );

    modport slave (
        input  vga_in,
        output pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, err_pulse, frame_sig
    );
endinterface

// File: rtl/vga_capture.sv
// Passive VGA receiver: recovers sync timing from the Pmod pins, locks onto the frame
// and emits pixel coordinates, colour and a per-frame rotate-xor signature.
module vga_capture #(
    parameter int H_ACTIVE = 640,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_TOTAL  = 525,
    parameter int SYNC_NEG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    vga_capture_if.slave io_vga
);
    localparam logic [9:0] L_H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] L_H_TOTAL = 10'(H_TOTAL);
    localparam logic [9:0] L_V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] L_X0      = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] L_X1      = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0] L_Y0      = 10'(V_SYNC + V_BACK - 1);
    localparam logic [9:0] L_Y1      = 10'(V_SYNC + V_BACK - 1 + V_ACTIVE);
    localparam logic [9:0] L_CNT_MAX = 10'h3FF;
    localparam logic       L_NEG     = 1'(SYNC_NEG);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_ALIGN  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    function automatic logic [15:0] sig_step(input logic [15:0] acc, input logic [5:0] rgb);
        sig_step = {acc[14:0], acc[15]} ^ {10'b0, rgb};
    endfunction

    logic [7:0]  r_sync1;
    logic [7:0]  r_sync2;
    logic        r_hs_d;
    logic        r_vs_d;
    logic [9:0]  r_hcnt;
    logic [9:0]  r_vcnt;
    logic        r_vpend;
    state_t      r_state;
    logic [15:0] r_acc;
    logic        r_pix_valid;
    logic [9:0]  r_pix_x;
    logic [9:0]  r_pix_y;
    logic [5:0]  r_pix_rgb;
    logic        r_frame_start;
    logic        r_locked;
    logic        r_err_pulse;
    logic [15:0] r_frame_sig;

    logic        w_hs;
    logic        w_vs;
    logic        w_hedge;
    logic        w_vedge;
    logic        w_fedge;
    logic        w_viol;
    logic        w_pix;
    logic [5:0]  w_rgb;
    logic [9:0]  w_hcnt;
    logic [9:0]  w_vcnt;

    assign w_hs    = r_sync2[7] ^ L_NEG;
    assign w_vs    = r_sync2[3] ^ L_NEG;
    assign w_hedge = w_hs & ~r_hs_d;
    assign w_vedge = w_vs & ~r_vs_d;
    // A vsync edge landing on the same cycle as the hsync edge counts as the frame edge.
    assign w_fedge = w_hedge & (r_vpend | w_vedge);
    assign w_rgb   = {r_sync2[0], r_sync2[4], r_sync2[1], r_sync2[5], r_sync2[2], r_sync2[6]};

    // Counts that belong to the sample currently leaving the synchronizer.
    always_comb begin
        w_hcnt = r_hcnt;
        w_vcnt = r_vcnt;
        if (w_hedge) begin
            w_hcnt = 10'd0;
        end else if (r_hcnt != L_CNT_MAX) begin
            w_hcnt = r_hcnt + 10'd1;
        end else begin
            w_hcnt = r_hcnt;
        end
        if (w_fedge) begin
            w_vcnt = 10'd0;
        end else if (w_hedge && (r_vcnt != L_CNT_MAX)) begin
            w_vcnt = r_vcnt + 10'd1;
        end else begin
            w_vcnt = r_vcnt;
        end
    end

    assign w_viol = (w_hedge && (r_hcnt != L_H_LAST))
                 || (!w_hedge && (w_hcnt == L_H_TOTAL))
                 || (w_fedge && (r_vcnt != L_V_LAST))
                 || (w_hedge && !w_fedge && (r_vcnt == L_V_LAST));

    assign w_pix = (r_state == S_LOCKED)
                && (w_hcnt >= L_X0) && (w_hcnt < L_X1)
                && (w_vcnt >= L_Y0) && (w_vcnt < L_Y1);

    // Sync history resets to "asserted" so reset release never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 8'h00;
            r_sync2 <= 8'h00;
            r_hs_d  <= 1'b1;
            r_vs_d  <= 1'b1;
        end else begin
            r_sync1 <= io_vga.vga_in;
            r_sync2 <= r_sync1;
            r_hs_d  <= w_hs;
            r_vs_d  <= w_vs;
        end
    end

    // Line/frame counters and the pending-vsync flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt  <= 10'd0;
            r_vcnt  <= 10'd0;
            r_vpend <= 1'b0;
        end else begin
            r_hcnt <= w_hcnt;
            r_vcnt <= w_vcnt;
            if (w_fedge) begin
                r_vpend <= 1'b0;
            end else if (w_vedge) begin
                r_vpend <= 1'b1;
            end else begin
                r_vpend <= r_vpend;
            end
        end
    end

    // Lock FSM with registered status, signature and pixel outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_HUNT;
            r_acc         <= 16'h0000;
            r_frame_sig   <= 16'h0000;
            r_frame_start <= 1'b0;
            r_err_pulse   <= 1'b0;
            r_locked      <= 1'b0;
            r_pix_valid   <= 1'b0;
            r_pix_x       <= 10'd0;
            r_pix_y       <= 10'd0;
            r_pix_rgb     <= 6'd0;
        end else begin
            r_frame_start <= 1'b0;
            r_err_pulse   <= 1'b0;
            if (w_pix) begin
                r_acc <= sig_step(r_acc, w_rgb);
            end
            case (r_state)
                S_HUNT: begin
                    r_locked <= 1'b0;
                    if (w_fedge) begin
                        r_state <= S_ALIGN;
                    end else begin
                        r_state <= S_HUNT;
                    end
                end
                S_ALIGN: begin
                    if (w_viol) begin
                        r_state  <= S_HUNT;
                        r_locked <= 1'b0;
                    end else if (w_fedge) begin
                        r_state       <= S_LOCKED;
                        r_locked      <= 1'b1;
                        r_frame_start <= 1'b1;
                    end else begin
                        r_state  <= S_ALIGN;
                        r_locked <= 1'b0;
                    end
                end
                S_LOCKED: begin
                    if (w_viol) begin
                        r_state     <= S_HUNT;
                        r_locked    <= 1'b0;
                        r_err_pulse <= 1'b1;
                        r_acc       <= 16'h0000;
                    end else if (w_fedge) begin
                        r_state       <= S_LOCKED;
                        r_locked      <= 1'b1;
                        r_frame_start <= 1'b1;
                        r_frame_sig   <= r_acc;
                        r_acc         <= 16'h0000;
                    end else begin
                        r_state  <= S_LOCKED;
                        r_locked <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_HUNT;
                    r_locked <= 1'b0;
                    r_acc    <= 16'h0000;
                end
            endcase
            r_pix_valid <= w_pix;
            r_pix_x     <= w_pix ? (w_hcnt - L_X0) : 10'd0;
            r_pix_y     <= w_pix ? (w_vcnt - L_Y0) : 10'd0;
            r_pix_rgb   <= w_pix ? w_rgb : 6'd0;
        end
    end

    assign io_vga.pix_valid   = r_pix_valid;
    assign io_vga.pix_x       = r_pix_x;
    assign io_vga.pix_y       = r_pix_y;
    assign io_vga.pix_rgb     = r_pix_rgb;
    assign io_vga.frame_start = r_frame_start;
    assign io_vga.locked      = r_locked;
    assign io_vga.err_pulse   = r_err_pulse;
    assign io_vga.frame_sig   = r_frame_sig;
endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture on a reduced 8x6 raster (16 clk lines, 14-line frames):
// the generator pushes expected pixels/signatures, an independent monitor pops and compares.
module tb_vga_capture;
    localparam int HA = 8;
    localparam int HS = 2;
    localparam int HB = 2;
    localparam int HT = 16;
    localparam int VA = 6;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int VT = 14;
    localparam int X0 = HS + HB;
    localparam int Y0 = VS + VB - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    vga_capture_if vif ();

    vga_capture #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT), .SYNC_NEG(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_vga(vif)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          fs_cnt  = 0;
    int          err_cnt = 0;
    logic [25:0] q_pix[$];
    logic [15:0] q_sig[$];
    logic [15:0] model_acc;
    logic [15:0] g_sig;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pix_valid"},   32'(vif.pix_valid),   32'd0);
        check({tag, "_pix_x"},       32'(vif.pix_x),       32'd0);
        check({tag, "_pix_y"},       32'(vif.pix_y),       32'd0);
        check({tag, "_pix_rgb"},     32'(vif.pix_rgb),     32'd0);
        check({tag, "_frame_start"}, 32'(vif.frame_start), 32'd0);
        check({tag, "_locked"},      32'(vif.locked),      32'd0);
        check({tag, "_err_pulse"},   32'(vif.err_pulse),   32'd0);
        check({tag, "_frame_sig"},   32'(vif.frame_sig),   32'd0);
    endtask

    // Monitor: compares every presented pixel and frame_start against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (vif.pix_valid) begin
                if (q_pix.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pix: got x=%0d y=%0d rgb=0x%0h, expected no pixel",
                             vif.pix_x, vif.pix_y, vif.pix_rgb);
                end else begin
                    check("pix_xy_rgb", 32'({vif.pix_x, vif.pix_y, vif.pix_rgb}), 32'(q_pix.pop_front()));
                end
            end
            if (!vif.locked) begin
                check("unlocked_pix_zero", 32'({vif.pix_valid, vif.pix_x, vif.pix_y, vif.pix_rgb}), 32'd0);
            end
            if (vif.frame_start) begin
                fs_cnt++;
                if (q_sig.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_frame_start: got sig 0x%0h, expected no pulse", vif.frame_sig);
                end else begin
                    check("frame_sig", 32'(vif.frame_sig), 32'(q_sig.pop_front()));
                end
            end
            if (vif.err_pulse) err_cnt++;
        end
    end

    // Drives lines l0..l1 of one frame; mode 0 black, 1 gradient, 2 single dot at (5,3).
    task automatic drive_frame(input int l0, input int c0, input int l1, input int mode,
                               input bit vs_on, input int exp_lim, input int short_line,
                               input int rst_line, input bit exp_lock, input bit push_fs,
                               input logic [15:0] fs_sig);
        int       ncol;
        int       x;
        int       y;
        bit       active;
        bit       dropped;
        logic [5:0] rgb;
        logic     hs;
        logic     vs;
        dropped   = 1'b0;
        model_acc = 16'h0000;
        if (push_fs) q_sig.push_back(fs_sig);
        for (int l = l0; l <= l1; l++) begin
            ncol = (l == short_line) ? HT - 1 : HT;
            for (int c = ((l == l0) ? c0 : 0); c < ncol; c++) begin
                @(negedge clk);
                if (l == 2 && c == 0) check("locked_line2", 32'(vif.locked), 32'(exp_lock));
                if (l == rst_line && c == X0 + 4) begin
                    check("pre_rst_locked", 32'(vif.locked), 32'd1);
                    #2;
                    rst_n = 1'b0;
                    #1;
                    check_all_zero("midrst");
                    q_pix.delete();
                    dropped = 1'b1;
                end
                if (l == rst_line && c == X0 + 8) rst_n = 1'b1;
                x      = c - X0;
                y      = l - Y0;
                active = (c >= X0) && (c < X0 + HA) && (l >= Y0) && (l < Y0 + VA);
                rgb    = 6'd0;
                if (active) begin
                    if (mode == 1) rgb = 6'(x * 5 + y * 9 + 1);
                    else if (mode == 2 && x == 5 && y == 3) rgb = 6'h3F;
                end
                hs = (c < HS) ? 1'b0 : 1'b1;
                vs = (vs_on && l < VS) ? 1'b0 : 1'b1;
                vif.vga_in = {hs, rgb[0], rgb[2], rgb[4], vs, rgb[1], rgb[3], rgb[5]};
                if (active && l < exp_lim && !dropped) begin
                    q_pix.push_back({10'(x), 10'(y), rgb});
                    model_acc = {model_acc[14:0], model_acc[15]} ^ {10'b0, rgb};
                end
            end
        end
    endtask

    initial begin
        vif.vga_in = 8'h88;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        //          l0 c0 l1    mode vs lim  short rst lock fs sig
        drive_frame(7, 5, VT-1, 0,   1, 0,   -1,   -1, 0,   0, 16'h0000);
        drive_frame(0, 0, VT-1, 0,   1, 0,   -1,   -1, 0,   0, 16'h0000);
        drive_frame(0, 0, VT-1, 1,   1, VT,  -1,   -1, 1,   1, 16'h0000);
        g_sig = model_acc;
        drive_frame(0, 0, VT-1, 0,   1, VT,  -1,   -1, 1,   1, g_sig);
        drive_frame(0, 0, VT-1, 2,   1, VT,  -1,   -1, 1,   1, 16'h0000);
        // Dot at pixel index 29 of 48 is rotated 18 times afterwards: 0x3F rotl 2 = 0x00FC.
        drive_frame(0, 0, VT-1, 0,   1, 6,   5,    -1, 1,   1, 16'h00FC);
        drive_frame(0, 0, VT-1, 0,   1, 0,   -1,   -1, 0,   0, 16'h0000);
        drive_frame(0, 0, VT-1, 1,   1, VT,  -1,   -1, 1,   1, 16'h00FC);
        g_sig = model_acc;
        check("err_after_short_line", 32'(err_cnt), 32'd1);
        drive_frame(0, 0, VT-1, 0,   1, VT,  -1,   -1, 1,   1, g_sig);
        for (int k = 0; k < 3; k++) begin
            drive_frame(0, 0, VT-1, 0, 0, 0, -1, -1, 0, 0, 16'h0000);
        end
        check("err_after_no_vsync", 32'(err_cnt), 32'd2);
        drive_frame(0, 0, VT-1, 0,   1, 0,   -1,   -1, 0,   0, 16'h0000);
        drive_frame(0, 0, VT-1, 1,   1, VT,  -1,   7,  1,   1, g_sig);
        drive_frame(0, 0, VT-1, 0,   1, 0,   -1,   -1, 0,   0, 16'h0000);
        drive_frame(0, 0, VT-1, 1,   1, VT,  -1,   -1, 1,   1, 16'h0000);
        g_sig = model_acc;
        drive_frame(0, 0, 3,    0,   1, VT,  -1,   -1, 1,   1, g_sig);
        check("pix_queue_drained", 32'(q_pix.size()), 32'd0);
        check("sig_queue_drained", 32'(q_sig.size()), 32'd0);
        check("frame_start_count", 32'(fs_cnt), 32'd9);
        check("err_pulse_count",   32'(err_cnt), 32'd2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
